// File: rtl/hbm_channel_healer_if.sv
// Bus between the per-channel ECC checkers / scrub engine / hot-spare PHY mux and the healer.
//   master: drives ecc_corr, ecc_uncorr, scrub_ack, swap_done; observes all healer outputs
//   slave : the healer itself
interface hbm_channel_healer_if #(
  parameter int unsigned NUM_CH = 8
) ();
  localparam int unsigned CH_W = $clog2(NUM_CH);

  logic [NUM_CH-1:0] ecc_corr;
  logic [NUM_CH-1:0] ecc_uncorr;
  logic              veto_pulse;
  logic              scrub_req;
  logic [CH_W-1:0]   scrub_ch;
  logic              scrub_ack;
  logic              swap_req;
  logic [CH_W-1:0]   swap_ch;
  logic              swap_done;
  logic              spare_used;
  logic [NUM_CH-1:0] retired_mask;
  logic              swap_fail;
  logic              degraded;

  modport master (
    output ecc_corr, ecc_uncorr, scrub_ack, swap_done,
    input  veto_pulse, scrub_req, scrub_ch, swap_req, swap_ch, spare_used, retired_mask,
           swap_fail, degraded
  );

  modport slave (
    input  ecc_corr, ecc_uncorr, scrub_ack, swap_done,
    output veto_pulse, scrub_req, scrub_ch, swap_req, swap_ch, spare_used, retired_mask,
           swap_fail, degraded
  );
endinterface

// File: rtl/hbm_channel_healer.sv
// Multi-channel HBM ECC healer.
// Tracks correctable-error rates per channel with leaky saturating counters, arbitrates scrub
// requests round-robin, pulses a veto on every uncorrectable error and runs one hot-spare swap
// that retires the first channel to cross the error threshold.
// Ports:
//   clk_2gt - sole clock, rising edge
//   rst_n   - synchronous active-low reset
//   bus     - slave side of hbm_channel_healer_if (ECC strobes, scrub and swap handshakes,
//             status flags); all outputs are registered
module hbm_channel_healer #(
  parameter int unsigned NUM_CH       = 8,
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned ERR_THRESH   = 16,
  parameter int unsigned LEAK_PERIOD  = 1024,
  parameter int unsigned SWAP_TIMEOUT = 200
) (
  input logic                clk_2gt,
  input logic                rst_n,
  hbm_channel_healer_if.slave bus
);

  localparam int unsigned CH_W   = $clog2(NUM_CH);
  localparam int unsigned LEAK_W = $clog2(LEAK_PERIOD);
  localparam int unsigned TMO_W  = $clog2(SWAP_TIMEOUT + 1);

  localparam logic [CNT_W-1:0]  CntMax   = '1;
  localparam logic [CNT_W-1:0]  Thresh   = CNT_W'(ERR_THRESH);
  localparam logic [LEAK_W-1:0] LeakLast = LEAK_W'(LEAK_PERIOD - 1);
  localparam logic [TMO_W-1:0]  TmoLast  = TMO_W'(SWAP_TIMEOUT - 1);
  localparam logic [CH_W-1:0]   ChLast   = CH_W'(NUM_CH - 1);

  typedef enum logic [1:0] {StIdle, StReq, StSpared} state_e;

  // Error tracking
  logic [NUM_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_CH-1:0]            uncorr_q, uncorr_d;
  logic [LEAK_W-1:0]            leak_q;
  logic                         leak_wrap;
  logic [NUM_CH-1:0]            corr_v, uncorr_v, clr_mask;
  logic                         veto_q;

  // Scrub arbiter
  logic [NUM_CH-1:0] pend_q, pend_d, avail;
  logic              scrub_req_q;
  logic [CH_W-1:0]   scrub_ch_q, ptr_q, pick_ch;
  logic              pick_vld;
  int                pick_dist;

  // Swap FSM
  state_e            state_q;
  logic              swap_req_q, spare_q, fail_q, degraded_q;
  logic [CH_W-1:0]   swap_ch_q;
  logic [TMO_W-1:0]  tmo_q;
  logic [NUM_CH-1:0] retired_q, swap_onehot, trig;
  logic              trig_any, swap_ok, swap_to;
  logic [CH_W-1:0]   trig_ch;

  // Retired channels are deaf to both strobe kinds.
  assign corr_v      = bus.ecc_corr & ~retired_q;
  assign uncorr_v    = bus.ecc_uncorr & ~retired_q;
  assign leak_wrap   = (leak_q == LeakLast);
  assign swap_onehot = NUM_CH'(1) << swap_ch_q;
  assign swap_ok     = (state_q == StReq) && bus.swap_done;
  assign swap_to     = (state_q == StReq) && !bus.swap_done && (tmo_q == TmoLast);
  // Counter/flag wipe: retired channels, plus the swap target on completion or timeout.
  assign clr_mask    = retired_q | ((swap_ok || swap_to) ? swap_onehot : '0);
  assign avail       = pend_q & ~retired_q;
  assign pick_vld    = |avail;

  // Trigger vector and lowest-index triggering channel.
  always_comb begin
    trig     = '0;
    trig_any = 1'b0;
    trig_ch  = '0;
    for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
      trig[i] = ((cnt_q[i] >= Thresh) || uncorr_q[i]) && !retired_q[i];
      if (trig[i]) begin
        trig_any = 1'b1;
        trig_ch  = CH_W'(i);
      end
    end
  end

  // Leaky saturating counters; an increment and a leak on the same cycle cancel out.
  always_comb begin
    cnt_d    = cnt_q;
    uncorr_d = uncorr_q | uncorr_v;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (clr_mask[i]) begin
        cnt_d[i]    = '0;
        uncorr_d[i] = 1'b0;
      end else if (corr_v[i] && !leak_wrap) begin
        if (cnt_q[i] != CntMax) cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else if (!corr_v[i] && leak_wrap && (cnt_q[i] != '0)) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
    end
  end

  // Pending mask: new strobes are applied after clears so a same-cycle set wins.
  always_comb begin
    pend_d = pend_q;
    if (scrub_req_q && bus.scrub_ack) pend_d[scrub_ch_q] = 1'b0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      // The request already on the bus for a retired channel is allowed to finish.
      if (retired_q[i] && !(scrub_req_q && (scrub_ch_q == CH_W'(i)))) pend_d[i] = 1'b0;
    end
    pend_d = pend_d | corr_v | uncorr_v;
  end

  // Round-robin pick: available channel with the smallest forward distance from the pointer.
  always_comb begin
    pick_dist = int'(NUM_CH);
    pick_ch   = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (avail[i] && (((i + int'(NUM_CH) - int'(ptr_q)) % int'(NUM_CH)) < pick_dist)) begin
        pick_dist = (i + int'(NUM_CH) - int'(ptr_q)) % int'(NUM_CH);
        pick_ch   = CH_W'(i);
      end
    end
  end

  always_ff @(posedge clk_2gt) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      uncorr_q    <= '0;
      pend_q      <= '0;
      leak_q      <= '0;
      veto_q      <= 1'b0;
      scrub_req_q <= 1'b0;
      scrub_ch_q  <= '0;
      ptr_q       <= '0;
    end else begin
      cnt_q    <= cnt_d;
      uncorr_q <= uncorr_d;
      pend_q   <= pend_d;
      leak_q   <= leak_wrap ? '0 : leak_q + LEAK_W'(1);
      veto_q   <= |uncorr_v;
      if (scrub_req_q) begin
        if (bus.scrub_ack) begin
          scrub_req_q <= 1'b0;
          ptr_q       <= (scrub_ch_q == ChLast) ? '0 : scrub_ch_q + CH_W'(1);
        end
      end else if (pick_vld) begin
        scrub_req_q <= 1'b1;
        scrub_ch_q  <= pick_ch;
      end
    end
  end

  // Swap sequencer; SPARED is terminal until reset.
  always_ff @(posedge clk_2gt) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      swap_req_q <= 1'b0;
      swap_ch_q  <= '0;
      tmo_q      <= '0;
      spare_q    <= 1'b0;
      retired_q  <= '0;
      fail_q     <= 1'b0;
      degraded_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (trig_any) begin
            state_q    <= StReq;
            swap_req_q <= 1'b1;
            swap_ch_q  <= trig_ch;
            tmo_q      <= '0;
          end
        end
        StReq: begin
          if (bus.swap_done) begin
            state_q    <= StSpared;
            swap_req_q <= 1'b0;
            spare_q    <= 1'b1;
            retired_q  <= swap_onehot;
          end else if (tmo_q == TmoLast) begin
            state_q    <= StIdle;
            swap_req_q <= 1'b0;
            fail_q     <= 1'b1;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end
        StSpared: begin
          if (trig_any) degraded_q <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.veto_pulse   = veto_q;
  assign bus.scrub_req    = scrub_req_q;
  assign bus.scrub_ch     = scrub_ch_q;
  assign bus.swap_req     = swap_req_q;
  assign bus.swap_ch      = swap_ch_q;
  assign bus.spare_used   = spare_q;
  assign bus.retired_mask = retired_q;
  assign bus.swap_fail    = fail_q;
  assign bus.degraded     = degraded_q;

endmodule

// File: tb/tb_hbm_channel_healer.sv
// Self-checking bench for hbm_channel_healer: directed scenarios plus random stimulus, all
// outputs compared every cycle against a behavioural model. A second small instance
// (CNT_W=4, LEAK_PERIOD=16) covers counter saturation and leak.
module tb_hbm_channel_healer;

  localparam int NCH  = 8;
  localparam int THR  = 16;
  localparam int LEAK = 1024;
  localparam int TMO  = 200;
  localparam int CMAX = 255;

  typedef enum int {MIdle, MReq, MSpared} mmode_e;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk = ~clk;

  hbm_channel_healer_if #(.NUM_CH(8)) bus_a ();
  hbm_channel_healer_if #(.NUM_CH(4)) bus_b ();

  hbm_channel_healer u_dut (
    .clk_2gt (clk),
    .rst_n   (rst_n),
    .bus     (bus_a)
  );

  hbm_channel_healer #(
    .NUM_CH       (4),
    .CNT_W        (4),
    .ERR_THRESH   (15),
    .LEAK_PERIOD  (16),
    .SWAP_TIMEOUT (1000)
  ) u_dut_b (
    .clk_2gt (clk),
    .rst_n   (rst_b),
    .bus     (bus_b)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  int     m_cnt [NCH];
  bit     m_unc [NCH];
  bit     m_pend[NCH];
  int     m_ptr, m_leak, m_sch, m_swch, m_elapsed, m_ret;
  bit     m_veto, m_sreq, m_fail, m_degr;
  mmode_e m_mode;

  logic [7:0] rmask;
  int         w, n;
  int         rr_exp[3] = '{0, 4, 7};
  logic [2:0] rr_ch;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_cnt[i]  = 0;
      m_unc[i]  = 1'b0;
      m_pend[i] = 1'b0;
    end
    m_ptr = 0; m_leak = 0; m_sch = 0; m_swch = 0; m_elapsed = 0; m_ret = -1;
    m_veto = 0; m_sreq = 0; m_fail = 0; m_degr = 0;
    m_mode = MIdle;
  endtask

  // One clock of the specified behaviour, computed from the current inputs.
  task automatic model_step();
    bit ce[NCH], ue[NCH], p_old[NCH];
    bit wrap, spare_now, fail_now, old_sreq, any_ue;
    int low, old_sch, pick;
    if (!rst_n) begin
      model_reset();
      return;
    end
    wrap = (m_leak == LEAK - 1);
    low = -1;
    any_ue = 0;
    for (int i = 0; i < NCH; i++) begin
      ce[i] = bus_a.ecc_corr[i] && (i != m_ret);
      ue[i] = bus_a.ecc_uncorr[i] && (i != m_ret);
      any_ue |= ue[i];
      if (low < 0 && (i != m_ret) && (m_cnt[i] >= THR || m_unc[i])) low = i;
      p_old[i] = m_pend[i];
    end
    spare_now = 0;
    fail_now  = 0;
    case (m_mode)
      MIdle: if (low >= 0) begin m_mode = MReq; m_swch = low; m_elapsed = 0; end
      MReq: begin
        if (bus_a.swap_done) begin
          m_mode = MSpared;
          spare_now = 1;
        end else begin
          m_elapsed++;
          if (m_elapsed == TMO) begin fail_now = 1; m_fail = 1; m_mode = MIdle; end
        end
      end
      default: if (low >= 0) m_degr = 1;
    endcase
    old_sreq = m_sreq;
    old_sch  = m_sch;
    for (int i = 0; i < NCH; i++) begin
      if (old_sreq && bus_a.scrub_ack && i == old_sch) m_pend[i] = 0;
      if (i == m_ret && !(old_sreq && old_sch == i)) m_pend[i] = 0;
      if (ce[i] || ue[i]) m_pend[i] = 1;
      if (i == m_ret || ((spare_now || fail_now) && i == m_swch)) begin
        m_cnt[i] = 0;
        m_unc[i] = 0;
      end else begin
        if (ce[i] && !wrap) m_cnt[i] = (m_cnt[i] == CMAX) ? CMAX : m_cnt[i] + 1;
        else if (wrap && !ce[i] && m_cnt[i] > 0) m_cnt[i] = m_cnt[i] - 1;
        if (ue[i]) m_unc[i] = 1;
      end
    end
    if (old_sreq) begin
      if (bus_a.scrub_ack) begin
        m_sreq = 0;
        m_ptr  = (old_sch + 1) % NCH;
      end
    end else begin
      pick = -1;
      for (int k = 0; k < NCH; k++) begin
        if (pick < 0 && p_old[(m_ptr + k) % NCH] && ((m_ptr + k) % NCH) != m_ret)
          pick = (m_ptr + k) % NCH;
      end
      if (pick >= 0) begin m_sreq = 1; m_sch = pick; end
    end
    m_veto = any_ue;
    m_leak = (m_leak + 1) % LEAK;
    if (spare_now) m_ret = m_swch;
  endtask

  task automatic compare_all();
    check("veto_pulse", 32'(bus_a.veto_pulse), 32'(m_veto));
    check("scrub_req", 32'(bus_a.scrub_req), 32'(m_sreq));
    check("scrub_ch", 32'(bus_a.scrub_ch), 32'(m_sch));
    check("swap_req", 32'(bus_a.swap_req), 32'(m_mode == MReq));
    check("swap_ch", 32'(bus_a.swap_ch), 32'(m_swch));
    check("spare_used", 32'(bus_a.spare_used), 32'(m_mode == MSpared));
    check("retired_mask", 32'(bus_a.retired_mask), (m_ret >= 0) ? (32'd1 << m_ret) : 32'd0);
    check("swap_fail", 32'(bus_a.swap_fail), 32'(m_fail));
    check("degraded", 32'(bus_a.degraded), 32'(m_degr));
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  function automatic logic [31:0] all_outs();
    return {19'd0, bus_a.veto_pulse, bus_a.scrub_req, bus_a.swap_req, bus_a.spare_used,
            bus_a.swap_fail, bus_a.degraded, bus_a.retired_mask};
  endfunction

  initial begin
    bus_a.ecc_corr = '0; bus_a.ecc_uncorr = '0; bus_a.scrub_ack = 0; bus_a.swap_done = 0;
    bus_b.ecc_corr = '0; bus_b.ecc_uncorr = '0; bus_b.scrub_ack = 0; bus_b.swap_done = 0;
    model_reset();

    // Reset with strobes toggling, then long idle.
    for (int c = 0; c < 3; c++) begin
      bus_a.ecc_corr   = 8'($urandom);
      bus_a.ecc_uncorr = 8'($urandom);
      bus_a.scrub_ack  = 1'($urandom);
      bus_a.swap_done  = 1'($urandom);
      cycle();
      check("rst_outs", all_outs(), 32'd0);
    end
    bus_a.ecc_corr = '0; bus_a.ecc_uncorr = '0; bus_a.scrub_ack = 0; bus_a.swap_done = 0;
    rst_n = 1;
    for (int c = 0; c < LEAK + 10; c++) cycle();
    check("idle_outs", all_outs(), 32'd0);

    // Threshold swap on channel 3.
    for (int c = 0; c < 16; c++) begin
      bus_a.ecc_corr = 8'h08;
      cycle();
    end
    bus_a.ecc_corr = '0;
    check("thr_no_req_yet", 32'(bus_a.swap_req), 32'd0);
    cycle();
    check("thr_swap_req", 32'(bus_a.swap_req), 32'd1);
    check("thr_swap_ch", 32'(bus_a.swap_ch), 32'd3);
    for (int c = 0; c < 4; c++) cycle();
    bus_a.swap_done = 1;
    cycle();
    bus_a.swap_done = 0;
    check("thr_spare_used", 32'(bus_a.spare_used), 32'd1);
    check("thr_retired", 32'(bus_a.retired_mask), 32'h08);
    check("thr_req_drop", 32'(bus_a.swap_req), 32'd0);
    bus_a.scrub_ack = 1;
    cycle();
    bus_a.scrub_ack = 0;
    bus_a.ecc_corr = 8'h08;
    for (int c = 0; c < 20; c++) cycle();
    bus_a.ecc_corr = '0;
    cycle();
    check("retired_ignored_deg", 32'(bus_a.degraded), 32'd0);
    check("retired_no_scrub", 32'(bus_a.scrub_req), 32'd0);

    // Uncorrectable on channel 5 after sparing.
    bus_a.ecc_uncorr = 8'h20;
    cycle();
    bus_a.ecc_uncorr = '0;
    check("veto_hi", 32'(bus_a.veto_pulse), 32'd1);
    cycle();
    check("veto_lo", 32'(bus_a.veto_pulse), 32'd0);
    check("degraded_set", 32'(bus_a.degraded), 32'd1);
    check("degraded_no_swap", 32'(bus_a.swap_req), 32'd0);

    // Round-robin scrub of channels 0, 4, 7.
    rst_n = 0;
    cycle();
    rst_n = 1;
    bus_a.ecc_corr = 8'h91;
    cycle();
    bus_a.ecc_corr = '0;
    for (int r = 0; r < 3; r++) begin
      w = 0;
      while (!bus_a.scrub_req && w < 10) begin
        cycle();
        w++;
      end
      check("rr_gap", 32'(w), 32'd1);
      rr_ch = bus_a.scrub_ch;
      check("rr_ch", 32'(rr_ch), 32'(rr_exp[r]));
      cycle();
      cycle();
      check("rr_hold_req", 32'(bus_a.scrub_req), 32'd1);
      check("rr_hold_ch", 32'(bus_a.scrub_ch), 32'(rr_ch));
      bus_a.scrub_ack = 1;
      cycle();
      bus_a.scrub_ack = 0;
      check("rr_drop", 32'(bus_a.scrub_req), 32'd0);
    end

    // Saturation and leak on the small instance (edges counted from its reset release).
    rst_b = 1;
    bus_b.ecc_corr = 4'b0010;
    for (int e = 1; e <= 20; e++) cycle();
    bus_b.ecc_corr = '0;
    check("sat_cnt", 32'(u_dut_b.cnt_q[1]), 32'd15);
    for (int e = 21; e <= 63; e++) cycle();
    check("leak_cnt_63", 32'(u_dut_b.cnt_q[1]), 32'd13);
    cycle();
    check("leak_cnt_64", 32'(u_dut_b.cnt_q[1]), 32'd12);
    rst_b = 0;
    cycle();
    rst_b = 1;
    for (int e = 1; e <= 15; e++) cycle();
    bus_b.ecc_corr = 4'b0010;
    cycle();
    check("inc_leak_cancel", 32'(u_dut_b.cnt_q[1]), 32'd0);
    cycle();
    bus_b.ecc_corr = '0;
    check("inc_after_wrap", 32'(u_dut_b.cnt_q[1]), 32'd1);

    // Swap timeout on channel 2, then reset mid-request on channel 6.
    rst_n = 0;
    cycle();
    rst_n = 1;
    bus_a.ecc_uncorr = 8'h04;
    cycle();
    bus_a.ecc_uncorr = '0;
    cycle();
    check("tmo_req", 32'(bus_a.swap_req), 32'd1);
    check("tmo_ch", 32'(bus_a.swap_ch), 32'd2);
    n = 1;
    w = 0;
    while (bus_a.swap_req && w < 300) begin
      cycle();
      w++;
      if (bus_a.swap_req) n++;
    end
    check("tmo_len", 32'(n), 32'(TMO));
    check("tmo_fail", 32'(bus_a.swap_fail), 32'd1);
    for (int c = 0; c < 5; c++) cycle();
    check("tmo_no_retrigger", 32'(bus_a.swap_req), 32'd0);
    bus_a.ecc_uncorr = 8'h40;
    cycle();
    bus_a.ecc_uncorr = '0;
    cycle();
    check("retry_req", 32'(bus_a.swap_req), 32'd1);
    check("retry_ch", 32'(bus_a.swap_ch), 32'd6);
    for (int c = 0; c < 10; c++) cycle();
    rst_n = 0;
    cycle();
    check("midreq_rst_req", 32'(bus_a.swap_req), 32'd0);
    check("midreq_rst_fail", 32'(bus_a.swap_fail), 32'd0);
    rst_n = 1;

    // Random traffic against the model.
    for (int c = 0; c < 15000; c++) begin
      rmask = '0;
      for (int b = 0; b < NCH; b++) if ($urandom_range(0, 99) < 6) rmask[b] = 1'b1;
      bus_a.ecc_corr   = rmask;
      bus_a.ecc_uncorr = ($urandom_range(0, 299) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'd0;
      bus_a.scrub_ack  = ($urandom_range(0, 99) < 30);
      bus_a.swap_done  = ($urandom_range(0, 79) == 0);
      rst_n            = ($urandom_range(0, 2999) != 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
